esp32_cpu_debug_ocimem_ctrl: RTL and testbench
==============================================

ESP32_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: esp32_cpu_debug_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the monitor RAM (256 x 32).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port jdo, input, 38, JTAG data from the debug-slave sysclk stage.
REQ-005 SHALL have port take_action_ocimem_a, input, 1, one-cycle strobe: load address, optionally read.
REQ-006 SHALL have port take_no_action_ocimem_a, input, 1, one-cycle strobe: auto-increment read.
REQ-007 SHALL have port take_action_ocimem_b, input, 1, one-cycle strobe: write data, then auto-increment.
REQ-008 SHALL have ports address (ADDR_W), read, write, debugaccess (1 each), writedata (32), byteenable (4), all inputs, CPU Avalon-MM slave.
REQ-009 SHALL have ports readdata (32) and waitrequest (1), outputs, CPU Avalon-MM slave.
REQ-010 SHALL have ports MonDReg (32), monitor_ready (1), monitor_error (1), outputs, returned to the debug-slave tck stage.

Function
REQ-011 SHALL hold internal MonAReg[ADDR_W-1:0], jtag_pend, jtag_is_wr and state in {IDLE, CPU_RD, JTAG_RD}.
REQ-012 SHALL, on take_action_ocimem_a: MonAReg <= jdo[24:17], clear monitor_error, clear monitor_ready; if jdo[35]=1, set jtag_pend with jtag_is_wr=0, else set monitor_ready next cycle.
REQ-013 SHALL, on take_no_action_ocimem_a: MonAReg <= MonAReg+1 (mod 2^ADDR_W), set jtag_pend with jtag_is_wr=0, clear monitor_ready.
REQ-014 SHALL, on take_action_ocimem_b: MonDReg <= jdo[34:3], set jtag_pend with jtag_is_wr=1, clear monitor_ready.
REQ-015 SHALL, when a strobe arrives while jtag_pend=1 or state=JTAG_RD, drop the strobe (no register change) and set monitor_error.
REQ-016 SHALL arbitrate in IDLE: CPU read/write has priority over jtag_pend; pending JTAG request is served the first IDLE cycle with no CPU request.
REQ-017 SHALL perform CPU write in one cycle (waitrequest=0) honouring byteenable, only when debugaccess=1; write with debugaccess=0 is discarded and sets monitor_error.
REQ-018 SHALL perform CPU read: IDLE->CPU_RD with waitrequest=1 in the request cycle; in CPU_RD readdata=RAM[address], waitrequest=0, return to IDLE (latency 2 cycles).
REQ-019 SHALL perform JTAG write from IDLE: RAM[MonAReg] <= MonDReg (all bytes), MonAReg <= MonAReg+1, clear jtag_pend, set monitor_ready next cycle.
REQ-020 SHALL perform JTAG read: IDLE->JTAG_RD issuing RAM read at MonAReg; in JTAG_RD MonDReg <= RAM data, clear jtag_pend, set monitor_ready, return to IDLE.
REQ-021 SHALL keep waitrequest=1 for a CPU request arriving while state is CPU_RD or JTAG_RD, until accepted in IDLE.
REQ-022 SHALL wrap MonAReg 0xFF->0x00 without error.
REQ-023 SHALL give simultaneous take_action_ocimem_a and take_action_ocimem_b priority to _a; _b is dropped and sets monitor_error.
REQ-024 SHALL hold readdata stable between accepted reads.

Reset
REQ-025 SHALL on reset_n=0 asynchronously force state=IDLE, MonAReg=0, MonDReg=0, jtag_pend=0, readdata=0, monitor_ready=0, monitor_error=0, waitrequest=1.
REQ-026 SHALL release waitrequest to 0 the first clk edge after reset_n deasserts; RAM contents are not reset.
REQ-027 SHALL abandon any in-flight CPU or JTAG operation on reset with no RAM write issued.

Verification
REQ-028 SHALL verify: _a with jdo[24:17]=0x10, jdo[35]=0, then _b with jdo[34:3]=0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11, monitor_ready=1.
REQ-029 SHALL verify: _a addr 0x10 jdo[35]=1 -> MonDReg=0xDEADBEEF within 3 cycles, monitor_ready=1; then _no_action_a -> MonDReg=RAM[0x11].
REQ-030 SHALL verify: CPU write (debugaccess=1, byteenable=4'b0011, 0x12345678) to 0x20 over prior 0 -> CPU read returns 0x00005678, waitrequest high exactly 1 cycle.
REQ-031 SHALL verify: CPU write with debugaccess=0 -> RAM unchanged, monitor_error=1; next _a clears it.
REQ-032 SHALL verify: _a addr 0xFF read, then _no_action_a -> MonAReg=0x00, MonDReg=RAM[0x00]; second strobe during pend -> monitor_error=1.
REQ-033 SHALL verify: CPU read and JTAG pend in same cycle -> CPU served first, JTAG completes one cycle later; reset_n pulse mid JTAG_RD -> all outputs at reset values.

Source files
------------

// File: rtl/esp32_cpu_debug_ocimem_ctrl.sv
// OCI monitor RAM controller: arbitrates a 256x32 debug RAM between the CPU
// Avalon-MM slave port and the JTAG debug-slave strobes (address/read/write).
module esp32_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic              debugaccess,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } cpu_req_t;

  state_t                    state, state_nxt;
  cpu_req_t                  req;
  logic [ADDR_W-1:0]         MonAReg;
  logic                      jtag_pend, jtag_is_wr, rst_done;
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  logic busy, cpu_go, cpu_rd, cpu_wr, cpu_err, jtag_go, jtag_wr, jtag_rd;
  logic st_a, st_n, st_b, dropped;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign req        = '{rd: read, wr: write, addr: address};

  // A JTAG request is outstanding until its RAM access has retired.
  assign busy    = jtag_pend | (state == JTAG_RD);
  assign cpu_go  = rst_done & (state == IDLE) & (req.rd | req.wr);
  assign cpu_rd  = cpu_go & req.rd;
  assign cpu_wr  = cpu_go & req.wr & ~req.rd;
  assign cpu_err = cpu_wr & ~debugaccess;
  assign jtag_go = rst_done & (state == IDLE) & ~(req.rd | req.wr) & jtag_pend;
  assign jtag_wr = jtag_go & jtag_is_wr;
  assign jtag_rd = jtag_go & ~jtag_is_wr;

  // At most one strobe is taken per cycle: _a, then _no_action_a, then _b.
  assign st_a    = take_action_ocimem_a & ~busy;
  assign st_n    = take_no_action_ocimem_a & ~busy & ~take_action_ocimem_a;
  assign st_b    = take_action_ocimem_b & ~busy & ~take_action_ocimem_a &
                   ~take_no_action_ocimem_a;
  assign dropped = (take_action_ocimem_a & busy) |
                   (take_no_action_ocimem_a & (busy | take_action_ocimem_a)) |
                   (take_action_ocimem_b &
                    (busy | take_action_ocimem_a | take_no_action_ocimem_a));

  always_comb begin
    state_nxt   = state;
    waitrequest = 1'b1;
    case (state)
      IDLE: begin
        waitrequest = req.rd;
        if (cpu_rd)       state_nxt = CPU_RD;
        else if (jtag_rd) state_nxt = JTAG_RD;
      end
      CPU_RD: begin
        waitrequest = 1'b0;
        state_nxt   = IDLE;
      end
      JTAG_RD: begin
        waitrequest = req.rd | req.wr;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_done) waitrequest = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rst_done      <= 1'b0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      jtag_pend     <= 1'b0;
      jtag_is_wr    <= 1'b0;
      readdata      <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;

      if (st_a)                               monitor_ready <= ~jdo[35];
      else if (st_n | st_b)                   monitor_ready <= 1'b0;
      else if (jtag_wr || state == JTAG_RD)   monitor_ready <= 1'b1;

      // A new error in the same cycle as an _a strobe must stay visible.
      if (dropped | cpu_err) monitor_error <= 1'b1;
      else if (st_a)         monitor_error <= 1'b0;

      if (st_a)                 MonAReg <= jdo[17 +: ADDR_W];
      else if (st_n | jtag_wr)  MonAReg <= MonAReg + 1'b1;

      if (st_b)                   MonDReg <= jdo[34:3];
      else if (state == JTAG_RD)  MonDReg <= mem[MonAReg];

      if (st_a)               jtag_pend <= jdo[35];
      else if (st_n | st_b)   jtag_pend <= 1'b1;
      else if (jtag_go)       jtag_pend <= 1'b0;

      if (st_a | st_n)  jtag_is_wr <= 1'b0;
      else if (st_b)    jtag_is_wr <= 1'b1;

      if (cpu_rd) readdata <= mem[req.addr];
    end
  end

  // RAM is not reset; writes are gated by rst_done so reset never commits one.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_LANES; b++) begin
      if (cpu_wr && debugaccess && byteenable[b]) mem[req.addr][b] <= writedata[8*b +: 8];
      else if (jtag_wr)                           mem[MonAReg][b]  <= MonDReg[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_esp32_cpu_debug_ocimem_ctrl.sv
// Directed bench for the OCI monitor RAM controller with a transaction-level
// model of the RAM and the monitor registers.
module tb_esp32_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_n = 1'b0, take_b = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0, write = 1'b0, debugaccess = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest, monitor_ready, monitor_error;

  esp32_cpu_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_n),
    .take_action_ocimem_b(take_b),
    .address(address), .read(read), .write(write), .debugaccess(debugaccess),
    .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .waitrequest(waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] exp_mem [256];
  logic [7:0]  exp_a;
  logic [31:0] exp_d, exp_rd;
  logic        exp_rdy, exp_err;
  logic        settled = 1'b0;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (settled) begin
      chk("MonDReg", MonDReg, exp_d);
      chk("monitor_ready", {31'b0, monitor_ready}, {31'b0, exp_rdy});
      chk("monitor_error", {31'b0, monitor_error}, {31'b0, exp_err});
      chk("readdata", readdata, exp_rd);
      chk("waitrequest_idle", {31'b0, waitrequest}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!monitor_ready && n < 8);
    chk(nm, {31'b0, (n <= 3)}, 32'd1);
  endtask

  task automatic chk_areg(input string nm, input logic [7:0] exp);
    chk(nm, {24'b0, dut.MonAReg}, {24'b0, exp});
  endtask

  task automatic do_reset();
    settled = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_waitrequest", {31'b0, waitrequest}, 32'd1);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_MonDReg", MonDReg, 32'd0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
    chk("rst_error", {31'b0, monitor_error}, 32'd0);
    chk_areg("rst_MonAReg", 8'h00);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    #1 chk("rel_waitrequest_hold", {31'b0, waitrequest}, 32'd1);
    tick();
    chk("rel_waitrequest_drop", {31'b0, waitrequest}, 32'd0);
    exp_a = 8'h00; exp_d = '0; exp_rd = '0; exp_rdy = 1'b0; exp_err = 1'b0;
    settled = 1'b1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    settled = 1'b0;
    jdo = '0; jdo[24:17] = addr; jdo[35] = rd;
    take_a = 1'b1; tick(); take_a = 1'b0;
    exp_a = addr; exp_err = 1'b0;
    if (rd) begin
      wait_ready("a_read_latency");
      exp_d = exp_mem[exp_a];
      tick();
    end
    exp_rdy = 1'b1;
    settled = 1'b1;
  endtask

  task automatic strobe_n();
    settled = 1'b0;
    take_n = 1'b1; tick(); take_n = 1'b0;
    exp_a = exp_a + 8'd1;
    wait_ready("n_read_latency");
    exp_d = exp_mem[exp_a]; exp_rdy = 1'b1;
    tick();
    settled = 1'b1;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    settled = 1'b0;
    jdo = '0; jdo[34:3] = d;
    take_b = 1'b1; tick(); take_b = 1'b0;
    wait_ready("b_write_latency");
    exp_d = d; exp_mem[exp_a] = d; exp_a = exp_a + 8'd1; exp_rdy = 1'b1;
    tick();
    settled = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    settled = 1'b0;
    address = addr; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    @(negedge clk);
    chk("write_waitrequest", {31'b0, waitrequest}, 32'd0);
    tick();
    write = 1'b0; debugaccess = 1'b0;
    if (dbg) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[addr][8*b +: 8] = d[8*b +: 8];
    end else exp_err = 1'b1;
    settled = 1'b1;
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [31:0] d);
    int n = 0;
    settled = 1'b0;
    address = addr; read = 1'b1;
    @(negedge clk);
    while (waitrequest && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("read_wait_cycles", n, 32'd1);
    chk("read_data_model", readdata, exp_mem[addr]);
    d = readdata;
    exp_rd = exp_mem[addr];
    tick();
    read = 1'b0;
    settled = 1'b1;
  endtask

  logic [31:0] rd;

  initial begin
    #2;
    do_reset();

    strobe_a(8'h10, 1'b0);
    chk_areg("a_load_addr", 8'h10);
    strobe_b(32'hDEADBEEF);
    chk_areg("b_incr_addr", 8'h11);
    chk("b_ready_lit", {31'b0, monitor_ready}, 32'd1);
    strobe_b(32'h11223344);
    cpu_read(8'h10, rd);
    chk("ram10_lit", rd, 32'hDEADBEEF);

    strobe_a(8'h10, 1'b1);
    chk("jtag_rd_lit", MonDReg, 32'hDEADBEEF);
    strobe_n();
    chk("jtag_rd_next_lit", MonDReg, 32'h11223344);

    cpu_write(8'h20, 32'h0, 4'hF, 1'b1);
    cpu_write(8'h20, 32'h12345678, 4'b0011, 1'b1);
    cpu_read(8'h20, rd);
    chk("byteen_lit", rd, 32'h00005678);

    cpu_write(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("nodbg_err_lit", {31'b0, monitor_error}, 32'd1);
    cpu_read(8'h20, rd);
    chk("nodbg_unchanged_lit", rd, 32'h00005678);
    strobe_a(8'h30, 1'b0);
    chk("a_clears_err_lit", {31'b0, monitor_error}, 32'd0);

    cpu_write(8'h00, 32'hA5A50F0F, 4'hF, 1'b1);
    cpu_write(8'h01, 32'h01010101, 4'hF, 1'b1);
    cpu_write(8'hFF, 32'hCAFEF00D, 4'hF, 1'b1);
    strobe_a(8'hFF, 1'b1);
    chk("rd_ff_lit", MonDReg, 32'hCAFEF00D);
    strobe_n();
    chk_areg("wrap_rd_addr", 8'h00);
    chk("wrap_rd_lit", MonDReg, 32'hA5A50F0F);

    // Second strobe while the first is still pending is dropped.
    settled = 1'b0;
    take_n = 1'b1; tick(); tick(); take_n = 1'b0;
    exp_a = exp_a + 8'd1; exp_err = 1'b1;
    wait_ready("dbl_latency");
    exp_d = exp_mem[exp_a]; exp_rdy = 1'b1;
    tick();
    settled = 1'b1;
    chk("dbl_err_lit", {31'b0, monitor_error}, 32'd1);
    chk_areg("dbl_addr_once", 8'h01);
    chk("dbl_data_lit", MonDReg, 32'h01010101);

    strobe_a(8'hFF, 1'b0);
    strobe_b(32'h0BADF00D);
    chk_areg("wrap_wr_addr", 8'h00);
    cpu_read(8'hFF, rd);
    chk("wrap_wr_lit", rd, 32'h0BADF00D);

    // _a and _b together: _a wins, _b is dropped with an error.
    settled = 1'b0;
    jdo = '0; jdo[34:3] = 32'h55555555; jdo[24:17] = 8'h40; jdo[35] = 1'b0;
    take_a = 1'b1; take_b = 1'b1; tick(); take_a = 1'b0; take_b = 1'b0;
    exp_a = 8'h40; exp_err = 1'b1; exp_rdy = 1'b1;
    settled = 1'b1;
    tick();
    chk_areg("ab_addr", 8'h40);
    chk("ab_MonDReg_lit", MonDReg, 32'h0BADF00D);

    // CPU read and pending JTAG write in the same IDLE cycle.
    strobe_a(8'h12, 1'b0);
    settled = 1'b0;
    jdo = '0; jdo[34:3] = 32'h77778888;
    take_b = 1'b1; tick(); take_b = 1'b0;
    address = 8'h10; read = 1'b1;
    @(negedge clk);
    chk("arb_c1_wait", {31'b0, waitrequest}, 32'd1);
    chk("arb_c1_ready", {31'b0, monitor_ready}, 32'd0);
    @(negedge clk);
    chk("arb_c2_wait", {31'b0, waitrequest}, 32'd0);
    chk("arb_c2_data_lit", readdata, 32'hDEADBEEF);
    chk("arb_c2_ready", {31'b0, monitor_ready}, 32'd0);
    tick(); read = 1'b0;
    @(negedge clk);
    chk("arb_c3_ready", {31'b0, monitor_ready}, 32'd0);
    @(negedge clk);
    chk("arb_c4_ready", {31'b0, monitor_ready}, 32'd1);
    exp_mem[8'h12] = 32'h77778888; exp_a = 8'h13; exp_d = 32'h77778888;
    exp_rdy = 1'b1; exp_rd = 32'hDEADBEEF;
    tick();
    settled = 1'b1;
    chk_areg("arb_addr", 8'h13);

    // Reset in the middle of a JTAG read.
    settled = 1'b0;
    jdo = '0; jdo[24:17] = 8'h11; jdo[35] = 1'b1;
    take_a = 1'b1; tick(); take_a = 1'b0;
    tick();
    do_reset();

    // Reset while a JTAG write is pending must not write the RAM.
    strobe_a(8'h12, 1'b0);
    settled = 1'b0;
    jdo = '0; jdo[34:3] = 32'hFFFF0000;
    take_b = 1'b1; tick(); take_b = 1'b0;
    do_reset();
    cpu_read(8'h12, rd);
    chk("rst_no_write_lit", rd, 32'h77778888);
    cpu_read(8'h10, rd);
    chk("ram_kept_lit", rd, 32'hDEADBEEF);

    settled = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
